multi_interval_timer: RTL and testbench

Parametrised multi-channel interval timer, an Avalon-MM slave with a 16-bit data path. It provides NUM_CH independent down-counters of CNT_W bits, each with its own prescaler, period, snapshot, control and status registers. Per-channel timeout interrupts are combined into a single irq line and a readable pending mask. It is the next-generation system timer for the NIOS peripheral set and replaces the single fixed 32-bit timer.

---
 rtl/multi_interval_timer.sv | 169 ++++++++++++++++
 tb/tb_multi_interval_timer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_interval_timer.sv
// multi_interval_timer: NUM_CH independent prescaled down-counters behind a
// 16-bit Avalon-MM slave. Address is {channel, reg[2:0]}; registered reads.
module multi_interval_timer #(
    parameter int          NUM_CH       = 4,
    parameter int          CNT_W        = 32,
    parameter int unsigned RESET_PERIOD = 9999,
    parameter int          AW           = (NUM_CH == 1) ? 3 : $clog2(NUM_CH) + 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          chipselect,
    input  logic          write_n,
    input  logic [AW-1:0] address,
    input  logic [15:0]   writedata,
    output logic [15:0]   readdata,
    output logic          irq
);

    localparam int CH_W = (AW > 3) ? AW - 3 : 1;

    logic                   wr;
    logic [2:0]             reg_sel;
    logic [CH_W-1:0]        ch_sel;
    logic [NUM_CH-1:0]      pending;
    logic [NUM_CH-1:0][15:0] ch_rdata;
    logic [15:0]            rd_next;

    assign wr      = chipselect & ~write_n;
    assign reg_sel = address[2:0];
    assign irq     = |pending;

    if (AW > 3) begin : g_ch_field
        assign ch_sel = address[AW-1:3];
    end else begin : g_no_ch_field
        assign ch_sel = '0;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic             sel;
        logic             wr_status;
        logic             wr_ctrl;
        logic             wr_per_l;
        logic             wr_per_h;
        logic             wr_snap;
        logic             wr_pre;
        logic             start;
        logic             stop;
        logic             to;
        logic             run;
        logic             zero_d;
        logic             force_reload;
        logic             zero;
        logic             tick;
        logic             hit_zero;
        logic [3:0]       ctrl;
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] counter;
        logic [CNT_W-1:0] snap;
        logic [CNT_W-1:0] cnt_next;
        logic [15:0]      prescale;
        logic [15:0]      pcount;
        logic [15:0]      rdata;

        assign sel       = wr && (ch_sel == CH_W'(i));
        assign wr_status = sel && (reg_sel == 3'd0);
        assign wr_ctrl   = sel && (reg_sel == 3'd1);
        assign wr_per_l  = sel && (reg_sel == 3'd2);
        assign wr_per_h  = sel && (reg_sel == 3'd3);
        assign wr_snap   = sel && ((reg_sel == 3'd4) || (reg_sel == 3'd5));
        assign wr_pre    = sel && (reg_sel == 3'd6);
        assign start     = wr_ctrl && writedata[2];
        assign stop      = wr_ctrl && writedata[3];

        assign zero     = (counter == '0);
        assign tick     = run && (pcount == '0);
        assign cnt_next = zero ? period : counter - CNT_W'(1);
        // One-shot stop is taken on the tick that lands on zero, so the
        // counter parks at 0 and a later START reloads on its first tick.
        assign hit_zero = tick && (cnt_next == '0) && !ctrl[1];

        assign pending[i] = to & ctrl[0];

        // Channel registers, prescaler, counter, RUN and TO tracking
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                to           <= 1'b0;
                run          <= 1'b0;
                zero_d       <= 1'b0;
                force_reload <= 1'b0;
                ctrl         <= '0;
                period       <= CNT_W'(RESET_PERIOD);
                counter      <= CNT_W'(RESET_PERIOD);
                snap         <= '0;
                prescale     <= '0;
                pcount       <= '0;
            end else begin
                force_reload <= wr_per_l || wr_per_h;

                if (wr_per_l)
                    period[15:0] <= writedata;
                if (wr_per_h)
                    period[CNT_W-1:16] <= writedata[CNT_W-17:0];
                if (wr_ctrl)
                    ctrl <= writedata[3:0];
                if (wr_pre)
                    prescale <= writedata;
                if (wr_snap)
                    snap <= counter;

                if (start || force_reload)
                    pcount <= prescale;
                else if (run)
                    pcount <= (pcount == '0) ? prescale : pcount - 16'd1;

                if (force_reload)
                    counter <= period;
                else if (tick)
                    counter <= cnt_next;

                if (start)
                    run <= 1'b1;
                else if (stop || force_reload || hit_zero)
                    run <= 1'b0;

                zero_d <= zero;

                if (wr_status)
                    to <= 1'b0;
                else if (zero && !zero_d)
                    to <= 1'b1;
            end
        end

        // Per-channel register readback
        always_comb begin
            rdata = '0;
            case (reg_sel)
                3'd0:    rdata = {14'd0, run, to};
                3'd1:    rdata = {12'd0, ctrl};
                3'd2:    rdata = period[15:0];
                3'd3:    rdata = 16'(period[CNT_W-1:16]);
                3'd4:    rdata = snap[15:0];
                3'd5:    rdata = 16'(snap[CNT_W-1:16]);
                3'd6:    rdata = prescale;
                default: rdata = 16'(pending);
            endcase
        end

        assign ch_rdata[i] = rdata;
    end

    // Channel select for readback; unpopulated channel indices read zero
    always_comb begin
        rd_next = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_sel == CH_W'(i))
                rd_next = ch_rdata[i];
        end
    end

    // Registered read data, refreshed every clock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata <= '0;
        else
            readdata <= rd_next;
    end

endmodule

// File: tb/tb_multi_interval_timer.sv
// Scoreboard bench for multi_interval_timer (5 channels so that channel
// indices 5..7 exist in the address space but are unpopulated).
module tb_multi_interval_timer;

    localparam int NCH = 5;
    localparam int TAW = $clog2(NCH) + 3;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           chipselect;
    logic           write_n;
    logic [TAW-1:0] address;
    logic [15:0]    writedata;
    logic [15:0]    readdata;
    logic           irq;

    int checks   = 0;
    int failures = 0;

    string       q_name[$];
    logic [15:0] q_exp[$];
    logic        rd_v = 1'b0;

    multi_interval_timer #(
        .NUM_CH(NCH),
        .CNT_W(32),
        .RESET_PERIOD(9999)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .chipselect(chipselect),
        .write_n(write_n),
        .address(address),
        .writedata(writedata),
        .readdata(readdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // A read presented at a rising edge yields data for the next falling edge
    always @(posedge clk) rd_v <= chipselect & write_n;

    always @(negedge clk) begin
        if (rd_v) begin
            checks++;
            if (q_exp.size() == 0) begin
                failures++;
                $display("FAIL unexpected_read: readdata=0x%04h with no expected entry", readdata);
            end else begin
                string       n;
                logic [15:0] e;
                n = q_name.pop_front();
                e = q_exp.pop_front();
                if (readdata !== e) begin
                    failures++;
                    $display("FAIL %s: got 0x%04h expected 0x%04h", n, readdata, e);
                end
            end
        end
    end

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", n, act, exp);
        end
    endtask

    // Each bus task starts at a falling edge and occupies exactly one clock
    task automatic wr(input int ch, input int r, input logic [15:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = TAW'(ch * 8 + r);
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input int ch, input int r, input logic [15:0] exp, input string n);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = TAW'(ch * 8 + r);
        q_name.push_back(n);
        q_exp.push_back(exp);
        @(negedge clk);
        chipselect = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = '0;
        writedata  = '0;
        #1;
        chk("reset_irq", {15'd0, irq}, 16'h0000);
        chk("reset_readdata", readdata, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset values of channel 0
        rd(0, 2, 16'h270F, "ch0_period_l_reset");
        rd(0, 3, 16'h0000, "ch0_period_h_reset");
        rd(0, 0, 16'h0000, "ch0_status_reset");
        chk("irq_after_reset", {15'd0, irq}, 16'h0000);

        // ch1: period 4, P=0, ITO|CONT|START
        wr(1, 6, 16'h0000);
        wr(1, 2, 16'h0004);                      // E0
        wr(1, 3, 16'h0000);                      // E1: counter=4
        wr(1, 1, 16'h0007);                      // E2: RUN=1
        wr(1, 4, 16'h0000);                      // E3: snap=4
        rd(1, 4, 16'h0004, "ch1_snap_4");        // E4
        wr(1, 5, 16'h0000);                      // E5: snap=2
        rd(1, 4, 16'h0002, "ch1_snap_2");        // E6
        wr(1, 4, 16'h0000);                      // E7: snap=0, TO sets
        rd(1, 4, 16'h0000, "ch1_snap_0");        // E8
        wr(1, 4, 16'h0000);                      // E9: snap=3 after reload
        rd(1, 4, 16'h0003, "ch1_snap_reload_3"); // E10
        rd(1, 0, 16'h0003, "ch1_status_to_run"); // E11
        rd(1, 7, 16'h0002, "ch1_pending");       // E12
        rd(0, 7, 16'h0002, "ch0_pending_alias"); // E13
        chk("ch1_irq_set", {15'd0, irq}, 16'h0001);
        wr(1, 0, 16'h0000);                      // E14: clear TO
        rd(1, 0, 16'h0002, "ch1_status_cleared"); // E15
        chk("ch1_irq_cleared", {15'd0, irq}, 16'h0000);
        idle(1);                                 // E16
        wr(1, 0, 16'h0000);                      // E17: clear beats arriving TO
        rd(1, 0, 16'h0002, "ch1_status_clear_wins"); // E18
        chk("ch1_irq_clear_wins", {15'd0, irq}, 16'h0000);
        idle(4);                                 // E19..E22: TO sets at E22
        chk("ch1_irq_next_to", {15'd0, irq}, 16'h0001);
        rd(1, 0, 16'h0003, "ch1_status_next_to"); // E23
        wr(1, 1, 16'h0008);
        wr(1, 0, 16'h0000);
        chk("ch1_irq_after_stop", {15'd0, irq}, 16'h0000);

        // ch2: period 2, P=3, one-shot
        wr(2, 6, 16'h0003);                      // F0
        wr(2, 2, 16'h0002);                      // F1
        wr(2, 3, 16'h0000);                      // F2: counter=2
        wr(2, 1, 16'h0004);                      // F3: START, pcount=3
        wr(2, 4, 16'h0000);                      // F4
        rd(2, 4, 16'h0002, "ch2_hold_2a");       // F5
        wr(2, 4, 16'h0000);                      // F6
        rd(2, 4, 16'h0002, "ch2_hold_2b");       // F7
        wr(2, 4, 16'h0000);                      // F8
        rd(2, 4, 16'h0001, "ch2_hold_1a");       // F9
        wr(2, 4, 16'h0000);                      // F10
        rd(2, 4, 16'h0001, "ch2_hold_1b");       // F11
        wr(2, 4, 16'h0000);                      // F12
        rd(2, 4, 16'h0000, "ch2_reached_0");     // F13
        rd(2, 0, 16'h0001, "ch2_status_oneshot"); // F14
        idle(5);
        wr(2, 4, 16'h0000);
        rd(2, 4, 16'h0000, "ch2_stays_0");
        rd(2, 0, 16'h0001, "ch2_status_still");

        // ch0: period 100, snapshot after 10 ticks, then mid-run period write
        wr(0, 2, 16'd100);                       // G0
        wr(0, 1, 16'h0006);                      // G1: counter=100, RUN=1
        idle(10);                                // G2..G11
        wr(0, 4, 16'h0000);                      // G12: snap=90
        rd(0, 4, 16'd90, "ch0_snap_l_90");       // G13
        rd(0, 5, 16'h0000, "ch0_snap_h_0");      // G14
        wr(0, 2, 16'd50);                        // G15
        wr(0, 4, 16'h0000);                      // G16: snap=86, counter<=50
        rd(0, 4, 16'd86, "ch0_snap_before_reload"); // G17
        rd(0, 0, 16'h0000, "ch0_run_cleared");   // G18
        wr(0, 4, 16'h0000);                      // G19
        rd(0, 4, 16'd50, "ch0_counter_reloaded"); // G20

        // START and STOP together: START wins
        wr(0, 1, 16'h000C);
        rd(0, 0, 16'h0002, "ch0_start_wins");
        rd(0, 1, 16'h000C, "ch0_control_stored");
        wr(0, 1, 16'h0008);
        rd(0, 0, 16'h0000, "ch0_stopped");

        // Unpopulated channel 6 (would alias ch2 if the top index bit were lost)
        wr(6, 2, 16'h1234);
        wr(6, 1, 16'h0007);
        rd(6, 2, 16'h0000, "ch6_period_reads_0");
        rd(6, 7, 16'h0000, "ch6_pending_reads_0");
        rd(2, 2, 16'h0002, "ch2_period_untouched");
        rd(2, 1, 16'h0004, "ch2_control_untouched");
        rd(4, 2, 16'h270F, "ch4_period_reset");

        // ch3 running with TO=1, then asynchronous reset
        wr(3, 2, 16'h0003);
        wr(3, 1, 16'h0007);
        idle(8);
        chk("ch3_irq_before_reset", {15'd0, irq}, 16'h0001);
        rd(3, 0, 16'h0003, "ch3_status_before_reset");
        idle(2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("irq_async_reset", {15'd0, irq}, 16'h0000);
        chk("readdata_async_reset", readdata, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        rd(3, 2, 16'h270F, "ch3_period_l_after_reset");
        rd(3, 3, 16'h0000, "ch3_period_h_after_reset");
        rd(3, 0, 16'h0000, "ch3_status_after_reset");
        rd(3, 1, 16'h0000, "ch3_control_after_reset");
        rd(3, 4, 16'h0000, "ch3_snap_after_reset");
        wr(3, 4, 16'h0000);
        rd(3, 4, 16'h270F, "ch3_counter_after_reset");
        rd(2, 6, 16'h0000, "ch2_prescale_after_reset");
        rd(1, 2, 16'h270F, "ch1_period_after_reset");
        rd(0, 7, 16'h0000, "pending_after_reset");
        chk("irq_after_second_reset", {15'd0, irq}, 16'h0000);

        idle(3);
        if (q_exp.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: %0d reads outstanding, expected 0", q_exp.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
